// File: rtl/muldiv_sequencer.sv
// Sequencer for RV32M MUL/MULHU/DIVU/REMU. It borrows the shared ALU for one
// ADD (shift-add multiply) or SUB (restoring divide) per cycle while busy.
module muldiv_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = OPCODE_LENGTH'(4'b0001);
  localparam logic [CNT_W-1:0]         LAST    = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [W-1:0]     hi, lo, d;
  logic [W-1:0]     hi_nxt, lo_nxt, rem_sh;
  logic             carry, take;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt     = state;
    alu_operation = '0;
    alu_srca      = '0;
    alu_srcb      = '0;
    rem_sh        = {hi[W-2:0], lo[W-1]};
    carry         = 1'b0;
    take          = 1'b0;
    hi_nxt        = hi;
    lo_nxt        = lo;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (op_q[1]) begin
          alu_operation = ALU_SUB;
          alu_srca      = rem_sh;
          alu_srcb      = d;
          // hi[W-1] is the 33rd remainder bit: when set, r' always exceeds d
          take = hi[W-1] | (rem_sh >= d);
          if (take) begin
            hi_nxt = alu_result;
            lo_nxt = {lo[W-2:0], 1'b1};
          end else begin
            hi_nxt = rem_sh;
            lo_nxt = {lo[W-2:0], 1'b0};
          end
        end else begin
          alu_operation = ALU_ADD;
          alu_srca      = hi;
          alu_srcb      = d;
          carry         = (alu_result < hi);
          if (lo[0]) {hi_nxt, lo_nxt} = {carry, alu_result, lo[W-1:1]};
          else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[W-1:1]};
        end
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      hi     <= '0;
      lo     <= '0;
      d      <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          cnt  <= '0;
          hi   <= '0;
          lo   <= op[1] ? a : b;
          d    <= op[1] ? b : a;
        end
        RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CNT_W'(1);
          // op[0] picks the high half (MULHU) or the remainder (REMU)
          if (state_nxt == DONE) result <= op_q[0] ? hi_nxt : lo_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, random operations against
// an arithmetic reference, plus busy-start and mid-run reset sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result, alu_srca, alu_srcb, alu_result;
  logic [3:0]  alu_operation;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared ALU as the core would provide it
  always_comb begin
    case (alu_operation)
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0001: alu_result = alu_srca - alu_srcb;
      default: alu_result = 32'h0;
    endcase
  end

  muldiv_sequencer #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_operation(alu_operation), .alu_result(alu_result)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] ref_model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    logic [63:0] p;
    p = {32'h0, x} * {32'h0, y};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it to IDLE; called at #1 after an edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output logic alu_ok,
                        output logic idle_ok);
    logic [3:0] code;
    code = o[1] ? 4'b0001 : 4'b0010;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    lat = -1;
    alu_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (alu_operation !== code || busy !== 1'b1) alu_ok = 1'b0;
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    res = result;
    tick();
    idle_ok = !busy && !done && (alu_operation == 4'h0) && (alu_srca == 0) &&
              (alu_srcb == 0) && (result === res);
  endtask

  vec_t        tbl[10];
  logic [31:0] res;
  int          lat;
  logic        aok, iok;
  logic [1:0]  ro;
  logic [31:0] ra, rb;
  int          saw_done;

  initial begin
    tbl[0] = '{2'd0, 32'd7,         32'd6,         32'd42};
    tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[3] = '{2'd2, 32'd100,       32'd7,         32'd14};
    tbl[4] = '{2'd3, 32'd100,       32'd7,         32'd2};
    tbl[5] = '{2'd2, 32'h8000_0000, 32'd1,         32'h8000_0000};
    tbl[6] = '{2'd2, 32'h1234,      32'd0,         32'hFFFF_FFFF};
    tbl[7] = '{2'd3, 32'h1234,      32'd0,         32'h1234};
    tbl[8] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    tbl[9] = '{2'd1, 32'h8000_0000, 32'd4,         32'd2};

    reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    tick();
    chk("reset_busy",   {31'h0, busy}, 32'h0);
    chk("reset_done",   {31'h0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_aluop",  {28'h0, alu_operation}, 32'h0);
    chk("reset_srca",   alu_srca, 32'h0);
    reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, aok, iok);
      chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 32'd32);
      chk($sformatf("vec%0d_aluop_run", i), {31'h0, aok}, 32'h1);
      chk($sformatf("vec%0d_idle_after", i), {31'h0, iok}, 32'h1);
    end

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, res, lat, aok, iok);
      chk($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), res, ref_model(ro, ra, rb));
    end

    // MUL 3x5 with start re-pulsed at edges 5 and 32; both must be ignored
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      if (e == 5 || e == 32) begin
        start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd3;
      end
      tick();
      start = 1'b0;
    end
    chk("busy_start_done", {31'h0, done}, 32'h1);
    chk("busy_start_result", result, 32'd15);
    // Request held across edges 33 and 34 must launch a new MUL 11x13
    start = 1'b1; op = 2'd0; a = 32'd11; b = 32'd13;
    tick();
    chk("after_done_pulse", {31'h0, done}, 32'h0);
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("next_start_accepted", {31'h0, (lat >= 0)}, 32'h1);
    chk("next_start_result", result, 32'd143);
    tick();

    // Asynchronous reset during iteration 10 of a DIVU
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_busy",   {31'h0, busy}, 32'h0);
    chk("abort_done",   {31'h0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    tick();
    reset = 1'b0;
    saw_done = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done || busy) saw_done++;
    end
    chk("abort_no_done", saw_done, 32'd0);
    chk("abort_result_held", result, 32'h0);
    run_op(2'd0, 32'd9, 32'd9, res, lat, aok, iok);
    chk("post_reset_mul", res, 32'd81);
    chk("post_reset_latency", lat, 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
